// File: rtl/or1k_store_buffer_drain_if.sv
// Store-buffer drain interface: the store buffer read port, the dbus write
// port and the error/status signals of or1k_store_buffer_drain.
// The master modport is the drain engine; slave is the buffer/arbiter side.
interface or1k_store_buffer_drain_if #(
    parameter int OW = 32
);
    logic            sb_empty_i;
    logic [OW-1:0]   sb_adr_i;
    logic [OW-1:0]   sb_dat_i;
    logic [OW-1:0]   sb_pc_i;
    logic [OW/8-1:0] sb_bsel_i;
    logic            sb_atomic_i;
    logic            sb_read_o;
    logic            drain_en_i;
    logic            dbus_req_o;
    logic [OW-1:0]   dbus_adr_o;
    logic [OW-1:0]   dbus_dat_o;
    logic [OW/8-1:0] dbus_bsel_o;
    logic            dbus_atomic_o;
    logic            dbus_ack_i;
    logic            dbus_err_i;
    logic            atomic_done_o;
    logic            bus_err_o;
    logic            err_timeout_o;
    logic [OW-1:0]   err_adr_o;
    logic [OW-1:0]   err_pc_o;
    logic            err_clear_i;
    logic            idle_o;

    modport master (
        input  sb_empty_i, sb_adr_i, sb_dat_i, sb_pc_i, sb_bsel_i, sb_atomic_i,
        input  drain_en_i, dbus_ack_i, dbus_err_i, err_clear_i,
        output sb_read_o, dbus_req_o, dbus_adr_o, dbus_dat_o, dbus_bsel_o,
        output dbus_atomic_o, atomic_done_o, bus_err_o, err_timeout_o,
        output err_adr_o, err_pc_o, idle_o
    );

    modport slave (
        output sb_empty_i, sb_adr_i, sb_dat_i, sb_pc_i, sb_bsel_i, sb_atomic_i,
        output drain_en_i, dbus_ack_i, dbus_err_i, err_clear_i,
        input  sb_read_o, dbus_req_o, dbus_adr_o, dbus_dat_o, dbus_bsel_o,
        input  dbus_atomic_o, atomic_done_o, bus_err_o, err_timeout_o,
        input  err_adr_o, err_pc_o, idle_o
    );
endinterface

// File: rtl/or1k_store_buffer_drain.sv
// Store buffer drain engine: pops buffered stores in FIFO order and issues
// each as a single outstanding dbus write. Bus errors are held with the
// faulting store's address/PC until err_clear_i.
// Optional write watchdog: define OR1K_SB_DRAIN_TIMEOUT_EN.
module or1k_store_buffer_drain #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_WIDTH        = 8
) (
    input logic                       clk,
    input logic                       rst,
    or1k_store_buffer_drain_if.master bus
);
    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int BW = OW / 8;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_ERROR} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] req_adr_q, req_adr_d;
    logic [OW-1:0] req_dat_q, req_dat_d;
    logic [OW-1:0] req_pc_q, req_pc_d;
    logic [BW-1:0] req_bsel_q, req_bsel_d;
    logic          req_atomic_q, req_atomic_d;
    logic [OW-1:0] err_adr_q, err_adr_d;
    logic [OW-1:0] err_pc_q, err_pc_d;
    logic          atomic_done_q, atomic_done_d;
    logic          pop_ok, resp_err, resp_ack, timeout_hit;
    logic          sb_read, dbus_req, bus_err, idle;

    assign pop_ok   = !bus.sb_empty_i && bus.drain_en_i;
    assign resp_err = (state_q == S_WRITE) && bus.dbus_err_i;
    // An error response wins over a simultaneous ack.
    assign resp_ack = (state_q == S_WRITE) && bus.dbus_ack_i && !bus.dbus_err_i;

`ifdef OR1K_SB_DRAIN_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d, wd_cnt_inc;
    logic                     err_timeout_q, err_timeout_d;

    assign wd_cnt_inc  = wd_cnt_q + TIMEOUT_WIDTH'(1);
    assign timeout_hit = (state_q == S_WRITE) && !bus.dbus_ack_i && !bus.dbus_err_i
                         && (&wd_cnt_inc);

    // Watchdog count restarts on the way into WRITE and advances each silent WRITE cycle
    always_comb begin
        wd_cnt_d      = wd_cnt_q;
        err_timeout_d = err_timeout_q;
        if (state_q == S_FETCH) begin
            wd_cnt_d = '0;
        end else if ((state_q == S_WRITE) && !bus.dbus_ack_i && !bus.dbus_err_i) begin
            wd_cnt_d = wd_cnt_inc;
        end
        if (timeout_hit) begin
            err_timeout_d = 1'b1;
        end else if (resp_err) begin
            err_timeout_d = 1'b0;
        end else if ((state_q == S_ERROR) && bus.err_clear_i) begin
            err_timeout_d = 1'b0;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.err_timeout_o = err_timeout_q;
`else
    localparam logic [TIMEOUT_WIDTH-1:0] NO_TIMEOUT = '0;
    assign timeout_hit       = |NO_TIMEOUT;
    assign bus.err_timeout_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop_ok) state_d = S_FETCH;
            S_FETCH: state_d = S_WRITE;
            S_WRITE: begin
                if (resp_err || timeout_hit) state_d = S_ERROR;
                else if (resp_ack)           state_d = pop_ok ? S_FETCH : S_IDLE;
            end
            S_ERROR: if (bus.err_clear_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: pop strobe, request, error hold and idle status
    always_comb begin
        sb_read  = 1'b0;
        dbus_req = 1'b0;
        bus_err  = 1'b0;
        idle     = 1'b0;
        case (state_q)
            S_IDLE: begin
                sb_read = pop_ok;
                idle    = bus.sb_empty_i;
            end
            S_WRITE: begin
                dbus_req = 1'b1;
                sb_read  = resp_ack && pop_ok;
            end
            S_ERROR: bus_err = 1'b1;
            default: ;
        endcase
    end

    // Request capture in FETCH, error capture on a failed or timed-out write
    always_comb begin
        req_adr_d     = req_adr_q;
        req_dat_d     = req_dat_q;
        req_pc_d      = req_pc_q;
        req_bsel_d    = req_bsel_q;
        req_atomic_d  = req_atomic_q;
        err_adr_d     = err_adr_q;
        err_pc_d      = err_pc_q;
        atomic_done_d = resp_ack && req_atomic_q;
        if (state_q == S_FETCH) begin
            req_adr_d    = bus.sb_adr_i;
            req_dat_d    = bus.sb_dat_i;
            req_pc_d     = bus.sb_pc_i;
            req_bsel_d   = bus.sb_bsel_i;
            req_atomic_d = bus.sb_atomic_i;
        end
        if (resp_err || timeout_hit) begin
            err_adr_d = req_adr_q;
            err_pc_d  = req_pc_q;
        end
    end

    // Request and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_adr_q     <= '0;
            req_dat_q     <= '0;
            req_pc_q      <= '0;
            req_bsel_q    <= '0;
            req_atomic_q  <= 1'b0;
            err_adr_q     <= '0;
            err_pc_q      <= '0;
            atomic_done_q <= 1'b0;
        end else begin
            req_adr_q     <= req_adr_d;
            req_dat_q     <= req_dat_d;
            req_pc_q      <= req_pc_d;
            req_bsel_q    <= req_bsel_d;
            req_atomic_q  <= req_atomic_d;
            err_adr_q     <= err_adr_d;
            err_pc_q      <= err_pc_d;
            atomic_done_q <= atomic_done_d;
        end
    end

    assign bus.sb_read_o     = sb_read;
    assign bus.dbus_req_o    = dbus_req;
    assign bus.dbus_adr_o    = req_adr_q;
    assign bus.dbus_dat_o    = req_dat_q;
    assign bus.dbus_bsel_o   = req_bsel_q;
    assign bus.dbus_atomic_o = req_atomic_q;
    assign bus.atomic_done_o = atomic_done_q;
    assign bus.bus_err_o     = bus_err;
    assign bus.err_adr_o     = err_adr_q;
    assign bus.err_pc_o      = err_pc_q;
    assign bus.idle_o        = idle;
endmodule

// File: tb/tb_or1k_store_buffer_drain.sv
// Testbench for or1k_store_buffer_drain: store buffer FIFO model, dbus
// responder with programmable wait/error, request scoreboard, table of
// single-store transactions plus multi-cycle sequences.
module tb_or1k_store_buffer_drain;
    localparam int OW = 32;
`ifdef OR1K_SB_DRAIN_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] pc;
        logic [3:0]  bsel;
        logic        atomic;
    } entry_t;

    typedef struct {
        entry_t e;
        int     wait_cyc;
        bit     err;
        bit     ack_too;
        bit     exp_bus_err;
        int     exp_atomic_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    or1k_store_buffer_drain_if #(.OW(OW)) bus_if ();

    or1k_store_buffer_drain #(
        .OPTION_OPERAND_WIDTH(OW),
        .TIMEOUT_WIDTH       (TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    entry_t sbq[$];
    entry_t expq[$];
    int     pop_cyc[$];
    int     comp_cyc[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     npop = 0;
    int     wcnt = 0;
    int     ack_wait = 0;
    int     n_atomic_done = 0;
    bit     err_mode = 0;
    bit     ack_with_err = 0;
    vec_t   vt[5];

    function automatic entry_t mk(logic [31:0] adr, logic [31:0] dat, logic [31:0] pc,
                                  logic [3:0] bsel, logic atomic);
        entry_t e;
        e.adr = adr; e.dat = dat; e.pc = pc; e.bsel = bsel; e.atomic = atomic;
        return e;
    endfunction

    task automatic check(string name, logic [95:0] act, logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired waiting for DUT (cycle %0d)", name, cyc);
    endtask

    task automatic push(entry_t e);
        sbq.push_back(e);
        expq.push_back(e);
        bus_if.sb_empty_i = 1'b0;
    endtask

    // One clock: respond on dbus, score the request, then advance the buffer model.
    task automatic cycle();
        entry_t e;
        bit     done;
        bit     pop;
        if (bus_if.dbus_req_o && wcnt >= ack_wait) begin
            bus_if.dbus_ack_i = !err_mode || ack_with_err;
            bus_if.dbus_err_i = err_mode;
        end else begin
            bus_if.dbus_ack_i = 1'b0;
            bus_if.dbus_err_i = 1'b0;
        end
        #1;
        done = bus_if.dbus_req_o && (bus_if.dbus_ack_i || bus_if.dbus_err_i);
        if (bus_if.dbus_req_o) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got adr %0h, expected no request", bus_if.dbus_adr_o);
            end else begin
                e = expq[0];
                check("req_fields",
                      {bus_if.dbus_adr_o, bus_if.dbus_dat_o, bus_if.dbus_bsel_o, bus_if.dbus_atomic_o},
                      {e.adr, e.dat, e.bsel, e.atomic});
                if (done) void'(expq.pop_front());
            end
            if (done) begin
                wcnt = 0;
                err_mode = 0;
                ack_with_err = 0;
                comp_cyc.push_back(cyc);
            end else begin
                wcnt++;
            end
        end
        check("no_pop_when_empty", bus_if.sb_read_o & bus_if.sb_empty_i, 0);
        if (bus_if.atomic_done_o) n_atomic_done++;
        pop = bus_if.sb_read_o;
        @(posedge clk);
        #1;
        bus_if.dbus_ack_i = 1'b0;
        bus_if.dbus_err_i = 1'b0;
        if (pop && sbq.size() > 0) begin
            e = sbq.pop_front();
            bus_if.sb_adr_i    = e.adr;
            bus_if.sb_dat_i    = e.dat;
            bus_if.sb_pc_i     = e.pc;
            bus_if.sb_bsel_i   = e.bsel;
            bus_if.sb_atomic_i = e.atomic;
            npop++;
            pop_cyc.push_back(cyc);
        end
        bus_if.sb_empty_i = (sbq.size() == 0);
        cyc++;
        #1;
    endtask

    task automatic run_until_drained(string name, int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (expq.size() == 0 && bus_if.idle_o) begin
                ok = 1;
                break;
            end
            cycle();
        end
        if (!ok) fail_bound(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int p0;
        bit ok;
        vt[0] = '{mk(32'h200, 32'hDEADBEEF, 32'h1000, 4'hF, 1'b0), 5, 0, 0, 0, 0};
        vt[1] = '{mk(32'h204, 32'h12345678, 32'h1004, 4'h3, 1'b1), 0, 0, 0, 0, 1};
        vt[2] = '{mk(32'h208, 32'h0000A5A5, 32'h1008, 4'h1, 1'b1), 2, 0, 0, 0, 1};
        vt[3] = '{mk(32'h20C, 32'hCAFEF00D, 32'h100C, 4'hC, 1'b0), 1, 1, 0, 1, 0};
        vt[4] = '{mk(32'h210, 32'h55AA55AA, 32'h1010, 4'h6, 1'b1), 0, 1, 1, 1, 0};

        bus_if.sb_empty_i  = 1'b1;
        bus_if.sb_adr_i    = '0;
        bus_if.sb_dat_i    = '0;
        bus_if.sb_pc_i     = '0;
        bus_if.sb_bsel_i   = '0;
        bus_if.sb_atomic_i = 1'b0;
        bus_if.drain_en_i  = 1'b1;
        bus_if.dbus_ack_i  = 1'b0;
        bus_if.dbus_err_i  = 1'b0;
        bus_if.err_clear_i = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_idle", bus_if.idle_o, 1);
        check("rst_ctrl", {bus_if.sb_read_o, bus_if.dbus_req_o, bus_if.bus_err_o,
                           bus_if.atomic_done_o, bus_if.err_timeout_o}, 0);
        check("rst_req_regs", {bus_if.dbus_adr_o, bus_if.dbus_dat_o, bus_if.dbus_bsel_o,
                               bus_if.dbus_atomic_o}, 0);
        check("rst_err_regs", {bus_if.err_adr_o, bus_if.err_pc_o}, 0);
        rst = 1'b0;

        // Three preloaded stores, zero-wait acks: requests 2, 4, 6 cycles after first pop
        ack_wait = 0;
        pop_cyc.delete();
        comp_cyc.delete();
        push(mk(32'h100, 32'h11111111, 32'h0F00, 4'hF, 1'b0));
        push(mk(32'h104, 32'h22222222, 32'h0F04, 4'hF, 1'b0));
        push(mk(32'h108, 32'h33333333, 32'h0F08, 4'hF, 1'b0));
        run_until_drained("burst3_drain", 40);
        check("burst3_count", comp_cyc.size(), 3);
        if (comp_cyc.size() == 3 && pop_cyc.size() > 0) begin
            for (int i = 0; i < 3; i++)
                check("burst3_latency", comp_cyc[i] - pop_cyc[0], 2 * (i + 1));
        end
        check("burst3_idle", bus_if.idle_o, 1);

        // Table of single-store transactions
        for (int r = 0; r < 5; r++) begin
            ack_wait = vt[r].wait_cyc;
            err_mode = vt[r].err;
            ack_with_err = vt[r].ack_too;
            n_atomic_done = 0;
            p0 = npop;
            push(vt[r].e);
            ok = 0;
            for (int i = 0; i < 40; i++) begin
                if (expq.size() == 0) begin
                    ok = 1;
                    break;
                end
                cycle();
            end
            if (!ok) fail_bound("vec_complete");
            cycle();
            cycle();
            check("vec_bus_err", bus_if.bus_err_o, vt[r].exp_bus_err);
            check("vec_atomic_done", n_atomic_done, vt[r].exp_atomic_done);
            check("vec_one_pop", npop - p0, 1);
            if (vt[r].exp_bus_err) begin
                check("vec_err_adr", bus_if.err_adr_o, vt[r].e.adr);
                check("vec_err_pc", bus_if.err_pc_o, vt[r].e.pc);
                bus_if.err_clear_i = 1'b1;
                cycle();
                bus_if.err_clear_i = 1'b0;
                check("vec_err_cleared", bus_if.bus_err_o, 0);
            end
            check("vec_idle", bus_if.idle_o, 1);
        end

        // Error with two stores queued behind: hold, no pops, then drain after clear
        ack_wait = 0;
        err_mode = 1;
        p0 = npop;
        push(mk(32'h300, 32'hBAD0BAD0, 32'h2000, 4'hF, 1'b0));
        push(mk(32'h304, 32'h44444444, 32'h2004, 4'hF, 1'b0));
        push(mk(32'h308, 32'h55555555, 32'h2008, 4'hF, 1'b0));
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.bus_err_o) begin
                ok = 1;
                break;
            end
            cycle();
        end
        if (!ok) fail_bound("err_taken");
        check("err_adr", bus_if.err_adr_o, 32'h300);
        check("err_pc", bus_if.err_pc_o, 32'h2000);
        repeat (4) cycle();
        check("err_hold", bus_if.bus_err_o, 1);
        check("err_no_pop", npop - p0, 1);
        check("err_no_req_idle", {bus_if.dbus_req_o, bus_if.idle_o}, 0);
        bus_if.err_clear_i = 1'b1;
        cycle();
        bus_if.err_clear_i = 1'b0;
        run_until_drained("err_rest_drain", 40);
        check("err_rest_pops", npop - p0, 3);
        check("err_adr_held", {bus_if.err_adr_o, bus_if.err_pc_o}, {32'h300, 32'h2000});

        // drain_en low with a store waiting: no pop, not idle
        bus_if.drain_en_i = 1'b0;
        p0 = npop;
        push(mk(32'h400, 32'h66666666, 32'h2400, 4'h5, 1'b0));
        repeat (4) cycle();
        check("stall_no_pop", npop - p0, 0);
        check("stall_state", {bus_if.idle_o, bus_if.dbus_req_o, bus_if.sb_read_o}, 0);
        bus_if.drain_en_i = 1'b1;
        run_until_drained("stall_release_drain", 40);
        check("stall_release_pop", npop - p0, 1);

        // Reset in the middle of a write
        ack_wait = 1000;
        push(mk(32'h500, 32'h77777777, 32'h2500, 4'hF, 1'b0));
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.dbus_req_o) begin
                ok = 1;
                break;
            end
            cycle();
        end
        if (!ok) fail_bound("rst_mid_req");
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        sbq.delete();
        expq.delete();
        bus_if.sb_empty_i = 1'b1;
        wcnt = 0;
        ack_wait = 0;
        rst = 1'b0;
        check("rst_mid_req_low", bus_if.dbus_req_o, 0);
        check("rst_mid_idle", bus_if.idle_o, 1);
        check("rst_mid_adr", bus_if.dbus_adr_o, 0);
        repeat (3) cycle();
        check("rst_mid_stays_idle", {bus_if.dbus_req_o, bus_if.idle_o}, 1);

`ifdef OR1K_SB_DRAIN_TIMEOUT_EN
        // Watchdog: no response, error after 15 WRITE cycles
        begin
            int w;
            ack_wait = 100000;
            push(mk(32'h600, 32'h88888888, 32'h3000, 4'hF, 1'b0));
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                if (bus_if.dbus_req_o) begin
                    ok = 1;
                    break;
                end
                cycle();
            end
            if (!ok) fail_bound("to_req");
            w = 0;
            while (!bus_if.bus_err_o && w < 40) begin
                cycle();
                w++;
            end
            check("to_write_cycles", w, 15);
            check("to_flag", bus_if.err_timeout_o, 1);
            check("to_err_adr", {bus_if.err_adr_o, bus_if.err_pc_o}, {32'h600, 32'h3000});
            expq.delete();
            wcnt = 0;
            ack_wait = 0;
            bus_if.err_clear_i = 1'b1;
            cycle();
            bus_if.err_clear_i = 1'b0;
            check("to_cleared", {bus_if.err_timeout_o, bus_if.bus_err_o}, 0);
        end
`else
        check("no_timeout_flag", bus_if.err_timeout_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
